button_bounce_emu: RTL and testbench

Controller that sequences a free-running pseudo-random source (a Galois LFSR) to emulate a mechanical pushbutton with contact bounce.
- On a press or release request, it drives a randomized number of bounce edges of randomized width, then settles at the requested level and signals completion.
- Sits in the buttonEmulator demo as the stimulus generator feeding debouncer/DUT benches and on-board demos.

---
 rtl/button_bounce_emu.sv | 145 ++++++++++++++
 tb/tb_button_bounce_emu.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_bounce_emu.sv
// Pushbutton contact-bounce emulator driven by a free-running Galois LFSR.
// Define BOUNCE_STATS_EN to add the edge_count / req_count statistics outputs.
module button_bounce_emu #(
  parameter int unsigned       LFSR_W        = 16,
  parameter logic [LFSR_W-1:0] SEED          = 16'hACE1,
  parameter int unsigned       BOUNCE_K_W    = 3,
  parameter int unsigned       SEG_W         = 8,
  parameter int unsigned       STABLE_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              press_req,
  input  logic              release_req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic              btn_out,
  output logic              busy,
  output logic              done,
  output logic [LFSR_W-1:0] lfsr_q
`ifdef BOUNCE_STATS_EN
  ,
  output logic [15:0]       edge_count,
  output logic [7:0]        req_count
`endif
);

  localparam int unsigned       TGL_W     = BOUNCE_K_W + 1;
  localparam int unsigned       SETTLE_W  = $clog2(STABLE_CYCLES + 1);
  localparam logic [LFSR_W-1:0] POLY_MASK = LFSR_W'(16'hB400);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [TGL_W-1:0]    toggles_left, toggles_nxt;
  logic [SEG_W-1:0]    seg_cnt, seg_nxt, seg_init;
  logic [SETTLE_W-1:0] settle_cnt, settle_nxt;
  logic [LFSR_W-1:0]   lfsr_step, lfsr_nxt;
  logic                btn_nxt, busy_nxt, done_nxt, accept;

  assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY_MASK) : (lfsr_q >> 1);
  // Odd segment length keeps the reload value nonzero (1..255 cycles).
  assign seg_init  = {lfsr_q[LFSR_W-1 -: SEG_W-1], 1'b1};

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      lfsr_q       <= SEED;
      toggles_left <= '0;
      seg_cnt      <= '0;
      settle_cnt   <= '0;
      btn_out      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      state        <= state_nxt;
      lfsr_q       <= lfsr_nxt;
      toggles_left <= toggles_nxt;
      seg_cnt      <= seg_nxt;
      settle_cnt   <= settle_nxt;
      btn_out      <= btn_nxt;
      busy         <= busy_nxt;
      done         <= done_nxt;
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_nxt   = state;
    toggles_nxt = toggles_left;
    seg_nxt     = seg_cnt;
    settle_nxt  = settle_cnt;
    btn_nxt     = btn_out;
    done_nxt    = 1'b0;
    accept      = 1'b0;
    lfsr_nxt    = lfsr_step;

    case (state)
      IDLE: begin
        if (seed_load) begin
          lfsr_nxt = (seed_in == '0) ? SEED : seed_in;
        end
        accept = (press_req && !btn_out) || (release_req && btn_out);
        if (accept) begin
          toggles_nxt = {lfsr_q[BOUNCE_K_W-1:0], 1'b1};
          seg_nxt     = seg_init;
          state_nxt   = BOUNCE;
        end
      end

      BOUNCE: begin
        if (seg_cnt == SEG_W'(1)) begin
          btn_nxt     = !btn_out;
          toggles_nxt = toggles_left - TGL_W'(1);
          seg_nxt     = seg_init;
          if (toggles_left == TGL_W'(1)) begin
            state_nxt  = SETTLE;
            settle_nxt = SETTLE_W'(STABLE_CYCLES);
          end
        end else begin
          seg_nxt = seg_cnt - SEG_W'(1);
        end
      end

      SETTLE: begin
        settle_nxt = settle_cnt - SETTLE_W'(1);
        if (settle_cnt == SETTLE_W'(1)) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

`ifdef BOUNCE_STATS_EN
  logic toggle;
  assign toggle = btn_nxt ^ btn_out;

  // Saturating edge counter and wrapping accepted-request counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_count <= '0;
      req_count  <= '0;
    end else begin
      if (toggle && (edge_count != 16'hFFFF)) begin
        edge_count <= edge_count + 16'd1;
      end
      if (accept) begin
        req_count <= req_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_bounce_emu.sv
// Self-checking bench for button_bounce_emu against a segment/edge-timing model.
// Define BOUNCE_STATS_EN to also check the statistics outputs.
module tb_button_bounce_emu;

  localparam logic [15:0] SEED          = 16'hACE1;
  localparam int          STABLE_CYCLES = 1000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        press_req = 1'b0;
  logic        release_req = 1'b0;
  logic        seed_load = 1'b0;
  logic [15:0] seed_in = '0;
  logic        btn_out, busy, done;
  logic [15:0] lfsr_q;
`ifdef BOUNCE_STATS_EN
  logic [15:0] edge_count;
  logic [7:0]  req_count;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] m_lfsr = SEED;
  logic        m_btn = 1'b0;
  bit          m_idle = 1'b1;
  int          m_edges = 0;
  int          m_reqs = 0;

  always #5 clk = ~clk;

  button_bounce_emu dut (
    .clk(clk),
    .rst_n(rst_n),
    .press_req(press_req),
    .release_req(release_req),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .btn_out(btn_out),
    .busy(busy),
    .done(done),
    .lfsr_q(lfsr_q)
`ifdef BOUNCE_STATS_EN
    ,
    .edge_count(edge_count),
    .req_count(req_count)
`endif
  );

  function automatic logic [15:0] f_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic int f_seg(input logic [15:0] v);
    return int'(v[15:8]) | 1;
  endfunction

  // One clock; the model LFSR follows the inputs the DUT sampled at this edge.
  task automatic tick();
    @(posedge clk);
    if (seed_load && m_idle) m_lfsr = (seed_in == 16'h0) ? SEED : seed_in;
    else m_lfsr = f_step(m_lfsr);
    #1;
  endtask

  task automatic run_op(input string name, input logic target, input bit both,
                        input bit noise, input bit seed_with_req,
                        input logic [15:0] sd, input bit b2b);
    logic [15:0] l0, cur;
    int k, n, t, next_edge, done_t, c, done_at, busy_bad, lfsr_bad, last_edge;
    int exp_edges[$];
    int obs_edges[$];
    logic prev_btn;

    l0  = m_lfsr;
    k   = int'(l0[2:0]);
    n   = 2 * k + 1;
    cur = seed_with_req ? ((sd == 16'h0) ? SEED : sd) : f_step(l0);
    t   = 1;
    next_edge = f_seg(l0);
    while (exp_edges.size() < n) begin
      if (t == next_edge) begin
        exp_edges.push_back(t);
        next_edge = t + f_seg(cur);
      end
      cur = f_step(cur);
      t++;
    end
    last_edge = exp_edges[n-1];
    done_t    = last_edge + STABLE_CYCLES;

    press_req   = target || both;
    release_req = !target || both;
    seed_load   = seed_with_req;
    seed_in     = sd;
    tick();
    m_idle = 1'b0;
    m_reqs++;
    press_req   = 1'b0;
    release_req = 1'b0;
    seed_load   = 1'b0;

    prev_btn = m_btn;
    done_at  = -1;
    busy_bad = 0;
    lfsr_bad = 0;
    c = 0;
    while (done_at < 0 && c < done_t + 50) begin
      tick();
      c++;
      if (btn_out !== prev_btn) begin
        obs_edges.push_back(c);
        prev_btn = btn_out;
      end
      if (done === 1'b1) done_at = c;
      if (busy !== ((c < done_t) ? 1'b1 : 1'b0)) busy_bad++;
      if (lfsr_q !== m_lfsr) lfsr_bad++;
      press_req   = 1'b0;
      release_req = 1'b0;
      seed_load   = 1'b0;
      if (noise && done_at < 0 && (c == 2 || c == last_edge + 5)) begin
        press_req   = 1'b1;
        release_req = (c == 2);
        seed_load   = 1'b1;
        seed_in     = 16'($urandom());
      end
    end
    press_req   = 1'b0;
    release_req = 1'b0;
    seed_load   = 1'b0;
    m_idle  = 1'b1;
    m_btn   = target;
    m_edges += obs_edges.size();

    n_checks++;
    if (obs_edges.size() !== n) begin
      n_fail++;
      $display("FAIL %s toggle_count: got %0d expected %0d", name, obs_edges.size(), n);
    end
    for (int i = 0; i < n && i < obs_edges.size(); i++) begin
      n_checks++;
      if (obs_edges[i] !== exp_edges[i]) begin
        n_fail++;
        $display("FAIL %s edge%0d_cycle: got %0d expected %0d", name, i, obs_edges[i], exp_edges[i]);
      end
    end
    n_checks++;
    if (done_at !== done_t) begin
      n_fail++;
      $display("FAIL %s done_cycle: got %0d expected %0d", name, done_at, done_t);
    end
    n_checks++;
    if (busy_bad !== 0) begin
      n_fail++;
      $display("FAIL %s busy_profile: got %0d bad cycles expected 0", name, busy_bad);
    end
    n_checks++;
    if (lfsr_bad !== 0) begin
      n_fail++;
      $display("FAIL %s lfsr_track: got %0d bad cycles expected 0", name, lfsr_bad);
    end
    n_checks++;
    if (btn_out !== target) begin
      n_fail++;
      $display("FAIL %s final_level: got %b expected %b", name, btn_out, target);
    end
    if (!b2b) begin
      tick();
      n_checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", name, done, busy);
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({btn_out, busy, done, lfsr_q} !== {3'b000, SEED}) begin
      n_fail++;
      $display("FAIL reset_values: got btn=%b busy=%b done=%b lfsr=%h expected 0 0 0 %h",
               btn_out, busy, done, lfsr_q, SEED);
    end
    rst_n  = 1'b1;
    m_lfsr = SEED;
  endtask

  task automatic test_reset_mid_bounce();
    press_req = 1'b1;
    tick();
    press_req = 1'b0;
    m_idle = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_busy_before: got %b expected 1", busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (btn_out !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: got btn=%b busy=%b done=%b expected 0 0 0", btn_out, busy, done);
    end
    n_checks++;
    if (lfsr_q !== SEED) begin
      n_fail++;
      $display("FAIL midreset_lfsr: got %h expected %h", lfsr_q, SEED);
    end
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_lfsr  = SEED;
    m_btn   = 1'b0;
    m_idle  = 1'b1;
    m_edges = 0;
    m_reqs  = 0;
  endtask

  task automatic test_seed_load();
    seed_load = 1'b1;
    seed_in   = 16'h0000;
    tick();
    n_checks++;
    if (lfsr_q !== 16'hACE1) begin
      n_fail++;
      $display("FAIL seed_zero: got %h expected %h", lfsr_q, 16'hACE1);
    end
    seed_in = 16'h0001;
    tick();
    n_checks++;
    if (lfsr_q !== 16'h0001) begin
      n_fail++;
      $display("FAIL seed_one: got %h expected %h", lfsr_q, 16'h0001);
    end
    seed_load = 1'b0;
    tick();
    n_checks++;
    if (lfsr_q !== 16'hB400) begin
      n_fail++;
      $display("FAIL seed_step: got %h expected %h", lfsr_q, 16'hB400);
    end
  endtask

  task automatic test_ignored_requests(input string name);
    int busy_hits, btn_chg;
    busy_hits = 0;
    btn_chg   = 0;
    if (m_btn) press_req = 1'b1;
    else release_req = 1'b1;
    repeat (6) begin
      tick();
      if (busy !== 1'b0) busy_hits++;
      if (btn_out !== m_btn) btn_chg++;
    end
    press_req   = 1'b0;
    release_req = 1'b0;
    n_checks++;
    if (busy_hits !== 0) begin
      n_fail++;
      $display("FAIL %s busy: got %0d busy cycles expected 0", name, busy_hits);
    end
    n_checks++;
    if (btn_chg !== 0) begin
      n_fail++;
      $display("FAIL %s btn: got %0d changed cycles expected 0", name, btn_chg);
    end
    n_checks++;
    if (lfsr_q !== m_lfsr) begin
      n_fail++;
      $display("FAIL %s lfsr: got %h expected %h", name, lfsr_q, m_lfsr);
    end
  endtask

  task automatic test_random_ops();
    logic [15:0] sd;
    for (int i = 0; i < 2; i++) begin
      repeat ($urandom_range(0, 20)) tick();
      sd = 16'($urandom());
      seed_load = 1'b1;
      seed_in   = sd;
      tick();
      seed_load = 1'b0;
      run_op($sformatf("random%0d", i), !m_btn, bit'($urandom_range(0, 1)), 1'b0, 1'b0, 16'h0, 1'b0);
    end
  endtask

`ifdef BOUNCE_STATS_EN
  task automatic test_stats();
    n_checks++;
    if (req_count !== 8'(m_reqs)) begin
      n_fail++;
      $display("FAIL stats_req_count: got %0d expected %0d", req_count, m_reqs);
    end
    n_checks++;
    if (edge_count !== 16'(m_edges)) begin
      n_fail++;
      $display("FAIL stats_edge_count: got %0d expected %0d", edge_count, m_edges);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_reset_mid_bounce();
    test_seed_load();
    test_ignored_requests("ignored_release_at_0");
    seed_load = 1'b1;
    seed_in   = 16'h1234;
    tick();
    seed_load = 1'b0;
    run_op("press", 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    test_ignored_requests("ignored_press_at_1");
    run_op("release", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    run_op("press_noise", 1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 1'b1);
    run_op("release_back_to_back", 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
    run_op("press_with_seed", 1'b1, 1'b0, 1'b0, 1'b1, 16'($urandom()), 1'b0);
    run_op("release_both_reqs", 1'b0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0);
    test_random_ops();
`ifdef BOUNCE_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
